// File: rtl/flash_page_buffer.sv
// Page buffer between a host byte port and a flash controller stream port.
// Optional XOR checksum of each transfer enabled by defining BUF_CHECKSUM_EN.
module flash_page_buffer #(
    parameter int PAGE_BYTES = 2048,
    parameter int AW = $clog2(PAGE_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BF_sel,
    input  logic          BF_we,
    input  logic [AW-1:0] BF_ad,
    input  logic [7:0]    BF_din,
    output logic [7:0]    BF_dout,
    output logic          BF_err,
    input  logic [1:0]    ctl_mode,
    input  logic          ctl_start,
    output logic          ctl_valid,
    input  logic          ctl_ready,
    output logic [7:0]    ctl_dout,
    input  logic          ctl_we,
    input  logic [7:0]    ctl_din,
    output logic          ctl_busy,
    output logic          ctl_done,
    output logic [7:0]    ctl_sum
);

    // state | meaning
    // IDLE  | host owns the memory port; waits for ctl_start
    // DRAIN | streams mem[cnt] out on ctl_dout with valid/ready
    // FILL  | writes ctl_din to mem[cnt] on each ctl_we
    // DONE  | one-cycle completion pulse, then IDLE
    typedef enum logic [1:0] {IDLE, DRAIN, FILL, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(PAGE_BYTES - 1);

    state_t        state, state_n;
    logic [7:0]    mem [PAGE_BYTES];
    logic [AW-1:0] cnt, cnt_n, mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we, host_rd, drain_rd;
    logic          xfer, last_xfer, start_ok;
    logic          pre_valid, valid_r;

    assign start_ok  = (state == IDLE) && ctl_start && (ctl_mode == 2'b01 || ctl_mode == 2'b10);
    assign xfer      = (state == DRAIN) && valid_r && ctl_ready;
    assign last_xfer = xfer && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // The single memory port is shared: host in IDLE, counter otherwise.
    // In DRAIN the read address runs one ahead on a transfer so ctl_dout
    // refreshes every cycle with ready high and simply re-reads when stalled.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mem_addr  = cnt;
        mem_we    = 1'b0;
        mem_wdata = ctl_din;
        host_rd   = 1'b0;
        drain_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (BF_sel) begin
                    mem_addr  = BF_ad;
                    mem_we    = BF_we;
                    mem_wdata = BF_din;
                    host_rd   = !BF_we;
                end
                if (start_ok) begin
                    state_n = (ctl_mode == 2'b01) ? DRAIN : FILL;
                    cnt_n   = '0;
                end
            end
            DRAIN: begin
                drain_rd = 1'b1;
                if (xfer) begin
                    cnt_n    = cnt + AW'(1);
                    mem_addr = cnt + AW'(1);
                    if (cnt == LAST) state_n = DONE;
                end
            end
            FILL: begin
                if (ctl_we) begin
                    mem_we = 1'b1;
                    cnt_n  = cnt + AW'(1);
                    if (cnt == LAST) state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pre_valid <= 1'b0;
            valid_r   <= 1'b0;
            BF_dout   <= 8'h00;
            BF_err    <= 1'b0;
            ctl_dout  <= 8'h00;
        end else begin
            cnt       <= cnt_n;
            // First valid two edges after the start: one edge to fetch mem[0].
            pre_valid <= (state == DRAIN) && !last_xfer;
            valid_r   <= (state == DRAIN) && pre_valid && !last_xfer;
            BF_err    <= BF_sel && (state != IDLE);
            if (host_rd)  BF_dout  <= mem[mem_addr];
            if (drain_rd) ctl_dout <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign ctl_valid = valid_r;
    assign ctl_busy  = (state == DRAIN) || (state == FILL);
    assign ctl_done  = (state == DONE);

`ifdef BUF_CHECKSUM_EN
    logic [7:0] sum_r;

    always_ff @(posedge clk) begin
        if (rst)                             sum_r <= 8'h00;
        else if (start_ok)                   sum_r <= 8'h00;
        else if (xfer)                       sum_r <= sum_r ^ ctl_dout;
        else if ((state == FILL) && ctl_we)  sum_r <= sum_r ^ ctl_din;
    end

    assign ctl_sum = sum_r;
`else
    assign ctl_sum = 8'h00;
`endif

endmodule

// File: tb/tb_flash_page_buffer.sv
// Directed bench for flash_page_buffer: host load/readback, drains with
// scoreboard, fills, host rejection during transfer and mid-fill reset.
module tb_flash_page_buffer;

    localparam int PB = 2048;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          BF_sel, BF_we;
    logic [AW-1:0] BF_ad;
    logic [7:0]    BF_din, BF_dout;
    logic          BF_err;
    logic [1:0]    ctl_mode;
    logic          ctl_start, ctl_valid, ctl_ready;
    logic [7:0]    ctl_dout;
    logic          ctl_we;
    logic [7:0]    ctl_din;
    logic          ctl_busy, ctl_done;
    logic [7:0]    ctl_sum;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_sum;

    always #5 clk = ~clk;

    flash_page_buffer #(.PAGE_BYTES(PB)) dut (
        .clk(clk), .rst(rst),
        .BF_sel(BF_sel), .BF_we(BF_we), .BF_ad(BF_ad), .BF_din(BF_din),
        .BF_dout(BF_dout), .BF_err(BF_err),
        .ctl_mode(ctl_mode), .ctl_start(ctl_start),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_dout(ctl_dout),
        .ctl_we(ctl_we), .ctl_din(ctl_din),
        .ctl_busy(ctl_busy), .ctl_done(ctl_done), .ctl_sum(ctl_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sum_exp(input logic [7:0] s);
`ifdef BUF_CHECKSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    task automatic host_read(input logic [AW-1:0] ad, input logic [7:0] exp, input string tag);
        BF_sel = 1'b1; BF_we = 1'b0; BF_ad = ad;
        tick;
        BF_sel = 1'b0;
        chk(tag, 32'(BF_dout), 32'(exp));
        tick;
        chk({tag, "_hold"}, 32'(BF_dout), 32'(exp));
    endtask

    // Drains one page, comparing every accepted byte against the scoreboard.
    task automatic drain_run(input bit toggle, input bit inject, input bit host_rd,
                             input logic [AW-1:0] rd_ad, input logic [7:0] rd_exp);
        bit         fin = 1'b0;
        bit         prev_stall = 1'b0;
        bit         rdy;
        int         extra = 0;
        logic [7:0] prev_dout = 8'h00;
        ctl_mode = 2'b01; ctl_start = 1'b1; ctl_ready = 1'b0;
        if (host_rd) begin BF_sel = 1'b1; BF_we = 1'b0; BF_ad = rd_ad; end
        tick;
        ctl_start = 1'b0; ctl_mode = 2'b00; BF_sel = 1'b0;
        chk("drain_busy", 32'(ctl_busy), 32'd1);
        chk("drain_valid_e0", 32'(ctl_valid), 32'd0);
        if (host_rd) chk("start_host_rd", 32'(BF_dout), 32'(rd_exp));
        tick;
        chk("drain_valid_e1", 32'(ctl_valid), 32'd0);
        tick;
        chk("drain_valid_e2", 32'(ctl_valid), 32'd1);
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            if (ctl_done) begin
                fin = 1'b1;
                chk("done_valid", 32'(ctl_valid), 32'd0);
                chk("drain_sum", 32'(ctl_sum), 32'(sum_exp(exp_sum)));
                chk("drain_left", 32'(sb.size()), 32'd0);
            end
            if (prev_stall) chk("stall_hold", 32'(ctl_dout), 32'(prev_dout));
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            ctl_ready = rdy;
            if (ctl_valid && rdy) begin
                if (sb.size() > 0) chk("drain_byte", 32'(ctl_dout), 32'(sb.pop_front()));
                else extra++;
            end
            prev_stall = ctl_valid && !rdy;
            prev_dout  = ctl_dout;
            if (inject) begin
                if (cyc == 20) begin
                    chk("err_idle", 32'(BF_err), 32'd0);
                    BF_sel = 1'b1; BF_we = 1'b1; BF_ad = '0; BF_din = 8'hFF;
                    ctl_start = 1'b1; ctl_mode = 2'b01;
                end else begin
                    BF_sel = 1'b0; BF_we = 1'b0; ctl_start = 1'b0; ctl_mode = 2'b00;
                end
                if (cyc == 21) chk("err_pulse", 32'(BF_err), 32'd1);
                if (cyc == 22) chk("err_clear", 32'(BF_err), 32'd0);
            end
            tick;
        end
        ctl_ready = 1'b0;
        chk("drain_finished", 32'(fin), 32'd1);
        chk("drain_extra", 32'(extra), 32'd0);
        chk("drain_idle_busy", 32'(ctl_busy), 32'd0);
        chk("drain_idle_done", 32'(ctl_done), 32'd0);
    endtask

    task automatic fill_run(input logic [7:0] body, input logic [7:0] lastb, input bit gaps);
        int n = 0;
        bit fin = 1'b0;
        ctl_mode = 2'b10; ctl_start = 1'b1;
        tick;
        ctl_start = 1'b0; ctl_mode = 2'b00;
        chk("fill_busy", 32'(ctl_busy), 32'd1);
        exp_sum = 8'h00;
        for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
            if (ctl_done) begin
                fin = 1'b1;
                chk("fill_sum", 32'(ctl_sum), 32'(sum_exp(exp_sum)));
                chk("fill_count", 32'(n), 32'(PB));
            end
            if (n < PB && !(gaps && cyc % 3 == 2)) begin
                ctl_we  = 1'b1;
                ctl_din = (n == PB - 1) ? lastb : body;
                exp_sum ^= ctl_din;
                n++;
            end else begin
                ctl_we  = 1'b0;
                ctl_din = 8'h00;
            end
            tick;
        end
        ctl_we = 1'b0;
        chk("fill_finished", 32'(fin), 32'd1);
        chk("fill_idle_busy", 32'(ctl_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; BF_sel = 1'b0; BF_we = 1'b0; BF_ad = '0; BF_din = 8'h00;
        ctl_mode = 2'b00; ctl_start = 1'b0; ctl_ready = 1'b0; ctl_we = 1'b0; ctl_din = 8'h00;
        tick; tick;
        chk("rst_bf_dout", 32'(BF_dout), 32'd0);
        chk("rst_bf_err", 32'(BF_err), 32'd0);
        chk("rst_valid", 32'(ctl_valid), 32'd0);
        chk("rst_ctl_dout", 32'(ctl_dout), 32'd0);
        chk("rst_busy", 32'(ctl_busy), 32'd0);
        chk("rst_done", 32'(ctl_done), 32'd0);
        chk("rst_sum", 32'(ctl_sum), 32'd0);
        rst = 1'b0;
        tick;

        // Reserved and idle modes must not start anything.
        ctl_mode = 2'b11; ctl_start = 1'b1; tick;
        chk("mode11_busy", 32'(ctl_busy), 32'd0);
        ctl_mode = 2'b00; tick;
        ctl_start = 1'b0;
        chk("mode00_busy", 32'(ctl_busy), 32'd0);
        tick;
        chk("mode_valid", 32'(ctl_valid), 32'd0);

        for (int i = 0; i < PB; i++) begin
            BF_sel = 1'b1; BF_we = 1'b1; BF_ad = AW'(i); BF_din = 8'(i);
            tick;
        end
        BF_sel = 1'b0; BF_we = 1'b0;
        host_read(AW'(5), 8'h05, "host_rd5");

        exp_sum = 8'h00;
        for (int i = 0; i < PB; i++) begin sb.push_back(8'(i)); exp_sum ^= 8'(i); end
        drain_run(1'b0, 1'b0, 1'b0, '0, 8'h00);

        exp_sum = 8'h00;
        for (int i = 0; i < PB; i++) begin sb.push_back(8'(i)); exp_sum ^= 8'(i); end
        drain_run(1'b1, 1'b1, 1'b0, '0, 8'h00);
        host_read(AW'(0), 8'h00, "mem0_kept");

        fill_run(8'hA5, 8'hA5, 1'b1);
        host_read(AW'(2047), 8'hA5, "fill_rd2047");
        host_read(AW'(0), 8'hA5, "fill_rd0");

        fill_run(8'h00, 8'h3C, 1'b0);
        host_read(AW'(2047), 8'h3C, "fill3c_rd2047");

        // Abort a fill after 100 bytes of 8'h77.
        ctl_mode = 2'b10; ctl_start = 1'b1; tick;
        ctl_start = 1'b0; ctl_mode = 2'b00;
        for (int i = 0; i < 100; i++) begin ctl_we = 1'b1; ctl_din = 8'h77; tick; end
        ctl_we = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", 32'(ctl_busy), 32'd0);
        chk("abort_done", 32'(ctl_done), 32'd0);
        chk("abort_bf_dout", 32'(BF_dout), 32'd0);
        tick;
        chk("abort_done2", 32'(ctl_done), 32'd0);

        exp_sum = 8'h00;
        for (int i = 0; i < PB; i++) begin
            logic [7:0] b;
            b = (i < 100) ? 8'h77 : ((i == PB - 1) ? 8'h3C : 8'h00);
            sb.push_back(b);
            exp_sum ^= b;
        end
        drain_run(1'b0, 1'b0, 1'b1, AW'(5), 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_page_buffer.md
FLASH_PAGE_BUFFER -- requirements
Module: flash_page_buffer

Interface
REQ-001 SHALL have parameter: PAGE_BYTES, 2048, page size in bytes (power of two); AW = log2(PAGE_BYTES) = 11 at default.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- BF_sel  in  1  host access select.
- BF_we  in  1  host write enable; read when 0.
- BF_ad  in  AW  host byte address.
- BF_din  in  8  host write data.
- BF_dout  out  8  host read data, registered.
- BF_err  out  1  one-cycle pulse: host access rejected.
- ctl_mode  in  2  00 idle, 01 drain (buffer->flash), 10 fill (flash->buffer), 11 reserved.
- ctl_start  in  1  start strobe for ctl_mode.
- ctl_valid  out  1  drain byte on ctl_dout valid.
- ctl_ready  in  1  consumer accepts drain byte.
- ctl_dout  out  8  drain data.
- ctl_we  in  1  fill byte strobe.
- ctl_din  in  8  fill data.
- ctl_busy  out  1  transfer in progress.
- ctl_done  out  1  one-cycle pulse: transfer complete.
- ctl_sum  out  8  XOR checksum of the last transfer.
REQ-003 Clock is clk; reset is rst, synchronous, active-high; single clock domain.

Function
REQ-004 SHALL store PAGE_BYTES x 8 bits in single-port synchronous memory.
REQ-005 SHALL implement FSM IDLE, DRAIN, FILL, DONE; ctl_busy=1 in DRAIN and FILL only.
REQ-006 IDLE: ctl_start with ctl_mode 01 -> DRAIN, 10 -> FILL; byte counter cleared to 0. Mode 00/11 is ignored.
REQ-007 ctl_start outside IDLE SHALL be ignored and SHALL NOT restart the counter.
REQ-008 DRAIN: ctl_valid first asserts 2 cycles after the accepting ctl_start edge. ctl_dout = mem[counter].
REQ-009 DRAIN handshake: a transfer occurs on ctl_valid && ctl_ready, then the counter increments.
REQ-010 DRAIN stall: while ctl_valid && !ctl_ready, ctl_dout SHALL hold stable.
REQ-011 DRAIN throughput: with ctl_ready held 1, one byte SHALL transfer per cycle.
REQ-012 FILL: each cycle with ctl_we=1 writes ctl_din to mem[counter] and increments the counter. ctl_we=0 stalls.
REQ-013 After transfer of byte PAGE_BYTES-1, the FSM SHALL enter DONE for exactly one cycle (ctl_done=1, ctl_valid=0), then IDLE. The counter wraps to 0.
REQ-014 Host access in IDLE with BF_sel=1:
- BF_we=1 writes BF_din to mem[BF_ad].
- BF_we=0 updates BF_dout with mem[BF_ad] one cycle later.
- BF_dout SHALL otherwise hold.
REQ-015 BF_sel=1 while ctl_busy or in DONE: access ignored, memory unchanged, BF_dout held, BF_err pulses 1 the following cycle.
REQ-016 ctl_start and host BF_sel in the same IDLE cycle: the host access completes and the transfer starts.

Reset
REQ-017 rst=1 at a clock edge SHALL force IDLE, counter=0, and these outputs to 0: BF_dout, BF_err, ctl_valid, ctl_dout, ctl_busy, ctl_done, ctl_sum.
REQ-018 Reset mid-transfer SHALL abort without ctl_done. Memory contents are not cleared.

Configuration
REQ-019 Macro BUF_CHECKSUM_EN:
- Defined: ctl_sum cleared at transfer start, XOR-accumulates every transferred byte (drain or fill), valid from the ctl_done cycle until the next start.
- Undefined: no accumulator logic; ctl_sum tied 8'h00.

Verification
REQ-020 Host writes mem[i]=i[7:0] for i=0..2047, then reads BF_ad=5 -> BF_dout=8'h05 one cycle later.
REQ-021 After REQ-020: drain with ctl_ready=1 -> bytes 00,01,..,FF repeating for 2048 transfers, ctl_done exactly once, then ctl_busy=0. With BUF_CHECKSUM_EN: ctl_sum=8'h00.
REQ-022 Drain with ctl_ready toggling 1,0 each cycle -> 2048 transfers, ctl_dout stable through every stall, no byte lost or duplicated.
REQ-023 Fill of 2048 bytes of 8'hA5 with ctl_we gaps, then host read of address 2047 -> 8'hA5. With BUF_CHECKSUM_EN: ctl_sum=8'h00. A fill of 2047x8'h00 plus 1x8'h3C gives ctl_sum=8'h3C.
REQ-024 Host write (BF_sel=1, BF_we=1, BF_ad=0, BF_din=8'hFF) during a drain -> BF_err pulses once, mem[0] unchanged. ctl_start during the drain is ignored.
REQ-025 rst after 100 fill bytes -> ctl_busy=0 next cycle, no ctl_done. The next drain starts at byte 0.
